// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: opcodes,
// funct codes, ALU selects, datapath mux selects and FSM state codes.
package multicycle_control_fsm_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_XOR = 3'd2;
   localparam logic [2:0] ALU_SLT = 3'd3;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_RS     = 2'd3;

   localparam logic [1:0] SRC_B_RT     = 2'd0;
   localparam logic [1:0] SRC_B_FOUR   = 2'd1;
   localparam logic [1:0] SRC_B_IMM    = 2'd2;
   localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

   localparam logic [1:0] REG_DST_RD  = 2'd0;
   localparam logic [1:0] REG_DST_RT  = 2'd1;
   localparam logic [1:0] REG_DST_R31 = 2'd2;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MDR  = 2'd1;
   localparam logic [1:0] WB_LINK = 2'd2;

   typedef enum logic [3:0] {
      ST_RESET,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC_R,
      ST_WB_R,
      ST_EXEC_I,
      ST_WB_I,
      ST_ADDR,
      ST_MEM_RD,
      ST_MEM_WR,
      ST_WB_MEM,
      ST_BRANCH,
      ST_JUMP,
      ST_JUMP_R,
      ST_JAL_WB,
      ST_FAULT
   } state_t;

   function automatic logic is_r_alu(input logic [5:0] fn);
      return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT);
   endfunction

   function automatic logic [2:0] alu_from_funct(input logic [5:0] fn);
      case (fn)
         FN_SUB:  return ALU_SUB;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_wait_timer.sv
// Memory wait timer: down-counter reloaded on clear, decremented per stalled
// cycle; expired flags the last stalled cycle still allowed.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LOAD_VAL = 8'(MEM_TIMEOUT - 1);

   logic [7:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= LOAD_VAL;
      end else if (clear) begin
         count <= LOAD_VAL;
      end else if (enable && (count != 8'd0)) begin
         count <= count - 8'd1;
      end
   end

   // A ready on the expired cycle still completes the access.
   assign expired = (count == 8'd0);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM for the MIPS-subset CPU: sequences fetch, decode,
// execute, memory and writeback, with bounded memory waits and fault capture.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RESET     | post-reset idle, all outputs 0
// FETCH     | read instruction at PC, PC <= PC+4 on ready
// DECODE    | classify opcode/funct, branch target into ALUOut
// EXEC_R    | rs op rt on the ALU
// WB_R      | write ALUOut to rd
// EXEC_I    | rs op signext(imm) on the ALU
// WB_I      | write ALUOut to rt
// ADDR      | load/store effective address
// MEM_RD    | data read, waits for ready
// MEM_WR    | data write, waits for ready
// WB_MEM    | write MDR to rt
// BRANCH    | compare rs/rt, conditional PC load from ALUOut
// JUMP      | PC <= {PC[31:28], imm26, 00}
// JUMP_R    | PC <= rs
// JAL_WB    | r31 <= PC+8 and jump
// FAULT     | illegal instruction or bus timeout, held until reset
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int ALU_SEL_W   = 3,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           opcode,
   input  logic [5:0]           funct,
   input  logic                 alu_zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 iord,
   output logic                 ir_wr,
   output logic                 pc_wr,
   output logic [1:0]           pc_src,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [ALU_SEL_W-1:0] alu_op,
   output logic                 reg_wr,
   output logic [1:0]           reg_dst,
   output logic [1:0]           wb_src,
   output logic                 instr_done,
   output logic                 illegal_op,
   output logic                 bus_error
);

   state_t     state, state_next;
   logic [2:0] alu_sel;
   logic       illegal_set;
   logic       bus_set;
   logic       tmr_clear;
   logic       tmr_enable;
   logic       tmr_expired;

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_RESET;
         illegal_op <= 1'b0;
         bus_error  <= 1'b0;
      end else begin
         state <= state_next;
         if (illegal_set) illegal_op <= 1'b1;
         if (bus_set)     bus_error  <= 1'b1;
      end
   end

   // Restart the wait budget whenever a memory-access state is entered.
   assign tmr_clear  = (state_next != state) &&
                       ((state_next == ST_FETCH) || (state_next == ST_MEM_RD) ||
                        (state_next == ST_MEM_WR));
   assign tmr_enable = mem_req && !mem_ready;
   assign alu_op     = ALU_SEL_W'(alu_sel);

   always_comb begin
      state_next  = state;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      iord        = 1'b0;
      ir_wr       = 1'b0;
      pc_wr       = 1'b0;
      pc_src      = PC_SRC_ALU;
      alu_src_a   = 1'b0;
      alu_src_b   = SRC_B_RT;
      alu_sel     = ALU_ADD;
      reg_wr      = 1'b0;
      reg_dst     = REG_DST_RD;
      wb_src      = WB_ALU;
      instr_done  = 1'b0;
      illegal_set = 1'b0;
      bus_set     = 1'b0;

      case (state)
         ST_RESET: state_next = ST_FETCH;

         ST_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRC_B_FOUR;
            if (mem_ready) begin
               ir_wr      = 1'b1;
               pc_wr      = 1'b1;
               state_next = ST_DECODE;
            end else if (tmr_expired) begin
               bus_set    = 1'b1;
               state_next = ST_FAULT;
            end
         end

         ST_DECODE: begin
            alu_src_b = SRC_B_IMM_SH;
            case (opcode)
               OP_RTYPE: begin
                  if (funct == FN_JR) begin
                     state_next = ST_JUMP_R;
                  end else if (is_r_alu(funct)) begin
                     state_next = ST_EXEC_R;
                  end else begin
                     illegal_set = 1'b1;
                     state_next  = ST_FAULT;
                  end
               end
               OP_J:            state_next = ST_JUMP;
               OP_JAL:          state_next = ST_JAL_WB;
               OP_ADDI, OP_XORI: state_next = ST_EXEC_I;
               OP_LW, OP_SW:    state_next = ST_ADDR;
               OP_BEQ, OP_BNE:  state_next = ST_BRANCH;
               default: begin
                  illegal_set = 1'b1;
                  state_next  = ST_FAULT;
               end
            endcase
         end

         ST_EXEC_R: begin
            alu_src_a  = 1'b1;
            alu_sel    = alu_from_funct(funct);
            state_next = ST_WB_R;
         end

         ST_WB_R: begin
            reg_wr     = 1'b1;
            instr_done = 1'b1;
            state_next = ST_FETCH;
         end

         ST_EXEC_I: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRC_B_IMM;
            alu_sel    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
            state_next = ST_WB_I;
         end

         ST_WB_I: begin
            reg_wr     = 1'b1;
            reg_dst    = REG_DST_RT;
            instr_done = 1'b1;
            state_next = ST_FETCH;
         end

         ST_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRC_B_IMM;
            state_next = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
         end

         ST_MEM_RD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               state_next = ST_WB_MEM;
            end else if (tmr_expired) begin
               bus_set    = 1'b1;
               state_next = ST_FAULT;
            end
         end

         ST_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_next = ST_FETCH;
            end else if (tmr_expired) begin
               bus_set    = 1'b1;
               state_next = ST_FAULT;
            end
         end

         ST_WB_MEM: begin
            reg_wr     = 1'b1;
            reg_dst    = REG_DST_RT;
            wb_src     = WB_MDR;
            instr_done = 1'b1;
            state_next = ST_FETCH;
         end

         // pc_wr follows alu_zero combinationally within the cycle.
         ST_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_sel    = ALU_SUB;
            pc_src     = PC_SRC_BRANCH;
            pc_wr      = (opcode == OP_BNE) ? !alu_zero : alu_zero;
            instr_done = 1'b1;
            state_next = ST_FETCH;
         end

         ST_JUMP: begin
            pc_src     = PC_SRC_JUMP;
            pc_wr      = 1'b1;
            instr_done = 1'b1;
            state_next = ST_FETCH;
         end

         ST_JUMP_R: begin
            pc_src     = PC_SRC_RS;
            pc_wr      = 1'b1;
            instr_done = 1'b1;
            state_next = ST_FETCH;
         end

         ST_JAL_WB: begin
            reg_wr     = 1'b1;
            reg_dst    = REG_DST_R31;
            wb_src     = WB_LINK;
            pc_src     = PC_SRC_JUMP;
            pc_wr      = 1'b1;
            instr_done = 1'b1;
            state_next = ST_FETCH;
         end

         ST_FAULT: state_next = ST_FAULT;

         default: state_next = ST_RESET;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle stimulus and the
// expected output bundle are queued together, then replayed and compared.
module tb_multicycle_control_fsm;

   localparam logic [5:0] T_OP_R    = 6'h00;
   localparam logic [5:0] T_OP_J    = 6'h02;
   localparam logic [5:0] T_OP_JAL  = 6'h03;
   localparam logic [5:0] T_OP_BEQ  = 6'h04;
   localparam logic [5:0] T_OP_BNE  = 6'h05;
   localparam logic [5:0] T_OP_ADDI = 6'h08;
   localparam logic [5:0] T_OP_XORI = 6'h0E;
   localparam logic [5:0] T_OP_LW   = 6'h23;
   localparam logic [5:0] T_OP_SW   = 6'h2B;
   localparam logic [5:0] T_FN_JR   = 6'h08;
   localparam logic [5:0] T_FN_ADD  = 6'h20;
   localparam logic [5:0] T_FN_SUB  = 6'h22;
   localparam logic [5:0] T_FN_SLT  = 6'h2A;

   typedef enum logic [3:0] {
      T_RST, T_FETCH, T_DECODE, T_EXEC_R, T_WB_R, T_EXEC_I, T_WB_I, T_ADDR,
      T_MEM_RD, T_MEM_WR, T_WB_MEM, T_BRANCH, T_JUMP, T_JUMP_R, T_JAL, T_FAULT
   } tb_st_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_wr;
      logic       pc_wr;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       reg_wr;
      logic [1:0] reg_dst;
      logic [1:0] wb_src;
      logic       instr_done;
      logic       illegal_op;
      logic       bus_error;
   } outs_t;

   typedef struct packed {
      tb_st_t     st;
      logic       rdy;
      logic       zero;
      logic [5:0] op;
      logic [5:0] fn;
   } stim_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       alu_zero;
   logic       mem_ready;
   logic       mem_req, mem_we, iord, ir_wr, pc_wr;
   logic [1:0] pc_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic       reg_wr;
   logic [1:0] reg_dst, wb_src;
   logic       instr_done, illegal_op, bus_error;

   int    checks   = 0;
   int    failures = 0;
   logic  exp_ill  = 1'b0;
   logic  exp_bus  = 1'b0;
   stim_t stim_q[$];
   outs_t exp_q[$];

   multicycle_control_fsm #(.ALU_SEL_W(3), .MEM_TIMEOUT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .alu_zero   (alu_zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .iord       (iord),
      .ir_wr      (ir_wr),
      .pc_wr      (pc_wr),
      .pc_src     (pc_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .reg_wr     (reg_wr),
      .reg_dst    (reg_dst),
      .wb_src     (wb_src),
      .instr_done (instr_done),
      .illegal_op (illegal_op),
      .bus_error  (bus_error)
   );

   always #5 clk = ~clk;

   function automatic outs_t dut_outs();
      outs_t o;
      o = '{mem_req, mem_we, iord, ir_wr, pc_wr, pc_src, alu_src_a, alu_src_b,
            alu_op, reg_wr, reg_dst, wb_src, instr_done, illegal_op, bus_error};
      return o;
   endfunction

   // Expected outputs of one cycle, written from the state descriptions.
   function automatic outs_t model(input tb_st_t s, input logic [5:0] op,
                                   input logic [5:0] fn, input logic rdy,
                                   input logic zero);
      outs_t o;
      o = '0;
      case (s)
         T_FETCH:  begin o.mem_req = 1; o.alu_src_b = 2'd1; o.ir_wr = rdy; o.pc_wr = rdy; end
         T_DECODE: o.alu_src_b = 2'd3;
         T_EXEC_R: begin
            o.alu_src_a = 1;
            o.alu_op = (fn == T_FN_SUB) ? 3'd1 : (fn == T_FN_SLT) ? 3'd3 : 3'd0;
         end
         T_WB_R:   begin o.reg_wr = 1; o.instr_done = 1; end
         T_EXEC_I: begin
            o.alu_src_a = 1; o.alu_src_b = 2'd2;
            o.alu_op = (op == T_OP_XORI) ? 3'd2 : 3'd0;
         end
         T_WB_I:   begin o.reg_wr = 1; o.reg_dst = 2'd1; o.instr_done = 1; end
         T_ADDR:   begin o.alu_src_a = 1; o.alu_src_b = 2'd2; end
         T_MEM_RD: begin o.mem_req = 1; o.iord = 1; end
         T_MEM_WR: begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; o.instr_done = rdy; end
         T_WB_MEM: begin o.reg_wr = 1; o.reg_dst = 2'd1; o.wb_src = 2'd1; o.instr_done = 1; end
         T_BRANCH: begin
            o.alu_src_a = 1; o.alu_op = 3'd1; o.pc_src = 2'd1; o.instr_done = 1;
            o.pc_wr = (op == T_OP_BEQ) ? zero : !zero;
         end
         T_JUMP:   begin o.pc_src = 2'd2; o.pc_wr = 1; o.instr_done = 1; end
         T_JUMP_R: begin o.pc_src = 2'd3; o.pc_wr = 1; o.instr_done = 1; end
         T_JAL:    begin
            o.reg_wr = 1; o.reg_dst = 2'd2; o.wb_src = 2'd2;
            o.pc_src = 2'd2; o.pc_wr = 1; o.instr_done = 1;
         end
         default: ;
      endcase
      return o;
   endfunction

   task automatic push(input tb_st_t s, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy, input logic zero);
      outs_t o;
      stim_q.push_back('{s, rdy, zero, op, fn});
      o = model(s, op, fn, rdy, zero);
      o.illegal_op = exp_ill;
      o.bus_error  = exp_bus;
      exp_q.push_back(o);
   endtask

   task automatic push_rtype(input logic [5:0] fn);
      push(T_FETCH, T_OP_R, fn, 1, 0);
      push(T_DECODE, T_OP_R, fn, 1, 0);
      push(T_EXEC_R, T_OP_R, fn, 1, 0);
      push(T_WB_R, T_OP_R, fn, 1, 0);
   endtask

   task automatic push_itype(input logic [5:0] op);
      push(T_FETCH, op, 6'h00, 1, 0);
      push(T_DECODE, op, 6'h00, 1, 0);
      push(T_EXEC_I, op, 6'h00, 1, 0);
      push(T_WB_I, op, 6'h00, 1, 0);
   endtask

   task automatic push_3cyc(input tb_st_t last, input logic [5:0] op,
                            input logic [5:0] fn, input logic zero);
      push(T_FETCH, op, fn, 1, zero);
      push(T_DECODE, op, fn, 1, zero);
      push(last, op, fn, 1, zero);
   endtask

   task automatic apply_next(output tb_st_t t);
      stim_t s;
      s = stim_q.pop_front();
      opcode    = s.op;
      funct     = s.fn;
      mem_ready = s.rdy;
      alu_zero  = s.zero;
      t         = s.st;
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      mem_ready = 1'b0;
      alu_zero  = 1'b0;
      opcode    = 6'h00;
      funct     = 6'h00;
      exp_ill   = 1'b0;
      exp_bus   = 1'b0;
      #1;
      checks++;
      if (dut_outs() !== outs_t'(0)) begin
         failures++;
         $display("FAIL reset_outputs actual=%h required=%h", dut_outs(), outs_t'(0));
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      tb_st_t t;
      outs_t  e;
      do_reset();
      push(T_RST, T_OP_R, 6'h00, 1, 0);
      push(T_FETCH, T_OP_R, 6'h00, 0, 0);
      while (stim_q.size() > 0) begin
         apply_next(t);
         e = exp_q.pop_front();
         checks++;
         if (dut_outs() !== e) begin
            failures++;
            $display("FAIL reset_seq at %s actual=%h required=%h", t.name(), dut_outs(), e);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_add();
      tb_st_t t;
      outs_t  e;
      int     done_cnt = 0;
      do_reset();
      push(T_RST, T_OP_R, T_FN_ADD, 1, 0);
      push_rtype(T_FN_ADD);
      push(T_FETCH, T_OP_R, T_FN_ADD, 0, 0);
      while (stim_q.size() > 0) begin
         apply_next(t);
         e = exp_q.pop_front();
         if (instr_done === 1'b1) done_cnt++;
         checks++;
         if (dut_outs() !== e) begin
            failures++;
            $display("FAIL add at %s actual=%h required=%h", t.name(), dut_outs(), e);
         end
         @(negedge clk);
      end
      checks++;
      if (done_cnt != 1) begin
         failures++;
         $display("FAIL add_done_pulses actual=%0d required=1", done_cnt);
      end
   endtask

   task automatic test_load_store();
      tb_st_t t;
      outs_t  e;
      do_reset();
      push(T_RST, T_OP_LW, 6'h00, 1, 0);
      push(T_FETCH, T_OP_LW, 6'h00, 1, 0);
      push(T_DECODE, T_OP_LW, 6'h00, 1, 0);
      push(T_ADDR, T_OP_LW, 6'h00, 1, 0);
      for (int i = 0; i < 3; i++) push(T_MEM_RD, T_OP_LW, 6'h00, 0, 0);
      push(T_MEM_RD, T_OP_LW, 6'h00, 1, 0);
      push(T_WB_MEM, T_OP_LW, 6'h00, 1, 0);
      // SW with stalls in both fetch and data phase: budget restarts per phase
      for (int i = 0; i < 2; i++) push(T_FETCH, T_OP_SW, 6'h00, 0, 0);
      push(T_FETCH, T_OP_SW, 6'h00, 1, 0);
      push(T_DECODE, T_OP_SW, 6'h00, 1, 0);
      push(T_ADDR, T_OP_SW, 6'h00, 1, 0);
      for (int i = 0; i < 3; i++) push(T_MEM_WR, T_OP_SW, 6'h00, 0, 0);
      push(T_MEM_WR, T_OP_SW, 6'h00, 1, 0);
      push(T_FETCH, T_OP_SW, 6'h00, 1, 0);
      push(T_DECODE, T_OP_SW, 6'h00, 1, 0);
      push(T_ADDR, T_OP_SW, 6'h00, 1, 0);
      push(T_MEM_WR, T_OP_SW, 6'h00, 1, 0);
      push(T_FETCH, T_OP_SW, 6'h00, 0, 0);
      while (stim_q.size() > 0) begin
         apply_next(t);
         e = exp_q.pop_front();
         checks++;
         if (dut_outs() !== e) begin
            failures++;
            $display("FAIL load_store at %s actual=%h required=%h", t.name(), dut_outs(), e);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      tb_st_t t;
      outs_t  e;
      do_reset();
      push(T_RST, T_OP_R, 6'h00, 1, 0);
      push_rtype(T_FN_SUB);
      push_rtype(T_FN_SLT);
      push_itype(T_OP_ADDI);
      push_itype(T_OP_XORI);
      push_3cyc(T_BRANCH, T_OP_BEQ, 6'h00, 1);
      push_3cyc(T_BRANCH, T_OP_BNE, 6'h00, 1);
      push_3cyc(T_BRANCH, T_OP_BEQ, 6'h00, 0);
      push_3cyc(T_BRANCH, T_OP_BNE, 6'h00, 0);
      push_3cyc(T_JAL, T_OP_JAL, 6'h00, 0);
      push_3cyc(T_JUMP, T_OP_J, 6'h00, 0);
      push_3cyc(T_JUMP_R, T_OP_R, T_FN_JR, 0);
      push(T_FETCH, T_OP_R, 6'h00, 0, 0);
      while (stim_q.size() > 0) begin
         apply_next(t);
         e = exp_q.pop_front();
         checks++;
         if (dut_outs() !== e) begin
            failures++;
            $display("FAIL back_to_back at %s op=%h fn=%h actual=%h required=%h",
                     t.name(), opcode, funct, dut_outs(), e);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_illegal();
      tb_st_t t;
      outs_t  e;
      logic [5:0] bad_op [2] = '{6'h3F, T_OP_R};
      logic [5:0] bad_fn [2] = '{6'h00, 6'h01};
      for (int k = 0; k < 2; k++) begin
         do_reset();
         push(T_RST, bad_op[k], bad_fn[k], 1, 0);
         push(T_FETCH, bad_op[k], bad_fn[k], 1, 0);
         push(T_DECODE, bad_op[k], bad_fn[k], 1, 0);
         exp_ill = 1'b1;
         for (int i = 0; i < 3; i++) push(T_FAULT, bad_op[k], bad_fn[k], 1, 1);
         while (stim_q.size() > 0) begin
            apply_next(t);
            e = exp_q.pop_front();
            checks++;
            if (dut_outs() !== e) begin
               failures++;
               $display("FAIL illegal_%0d at %s actual=%h required=%h", k, t.name(), dut_outs(), e);
            end
            @(negedge clk);
         end
      end
      do_reset();
      push(T_RST, T_OP_R, T_FN_ADD, 1, 0);
      push_rtype(T_FN_ADD);
      while (stim_q.size() > 0) begin
         apply_next(t);
         e = exp_q.pop_front();
         checks++;
         if (dut_outs() !== e) begin
            failures++;
            $display("FAIL illegal_recover at %s actual=%h required=%h", t.name(), dut_outs(), e);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_timeout();
      tb_st_t t;
      outs_t  e;
      do_reset();
      push(T_RST, T_OP_ADDI, 6'h00, 0, 0);
      for (int i = 0; i < 4; i++) push(T_FETCH, T_OP_ADDI, 6'h00, 0, 0);
      exp_bus = 1'b1;
      for (int i = 0; i < 2; i++) push(T_FAULT, T_OP_ADDI, 6'h00, 1, 0);
      while (stim_q.size() > 0) begin
         apply_next(t);
         e = exp_q.pop_front();
         checks++;
         if (dut_outs() !== e) begin
            failures++;
            $display("FAIL timeout at %s actual=%h required=%h", t.name(), dut_outs(), e);
         end
         @(negedge clk);
      end
      do_reset();
      push(T_RST, T_OP_ADDI, 6'h00, 0, 0);
      for (int i = 0; i < 3; i++) push(T_FETCH, T_OP_ADDI, 6'h00, 0, 0);
      push(T_FETCH, T_OP_ADDI, 6'h00, 1, 0);
      push(T_DECODE, T_OP_ADDI, 6'h00, 1, 0);
      push(T_EXEC_I, T_OP_ADDI, 6'h00, 1, 0);
      push(T_WB_I, T_OP_ADDI, 6'h00, 1, 0);
      while (stim_q.size() > 0) begin
         apply_next(t);
         e = exp_q.pop_front();
         checks++;
         if (dut_outs() !== e) begin
            failures++;
            $display("FAIL ready_at_limit at %s actual=%h required=%h", t.name(), dut_outs(), e);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_write();
      tb_st_t t;
      outs_t  e;
      do_reset();
      push(T_RST, T_OP_SW, 6'h00, 1, 0);
      push(T_FETCH, T_OP_SW, 6'h00, 1, 0);
      push(T_DECODE, T_OP_SW, 6'h00, 1, 0);
      push(T_ADDR, T_OP_SW, 6'h00, 1, 0);
      push(T_MEM_WR, T_OP_SW, 6'h00, 0, 0);
      push(T_MEM_WR, T_OP_SW, 6'h00, 0, 0);
      while (stim_q.size() > 0) begin
         apply_next(t);
         e = exp_q.pop_front();
         checks++;
         if (dut_outs() !== e) begin
            failures++;
            $display("FAIL mid_write at %s actual=%h required=%h", t.name(), dut_outs(), e);
         end
         @(negedge clk);
      end
      mem_ready = 1'b0;
      #1;
      checks++;
      if (mem_we !== 1'b1) begin
         failures++;
         $display("FAIL mid_write_we_before actual=%b required=1", mem_we);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({mem_we, mem_req, pc_wr, reg_wr} !== 4'b0000) begin
         failures++;
         $display("FAIL mid_write_abort actual=%b required=0000", {mem_we, mem_req, pc_wr, reg_wr});
      end
      do_reset();
      push(T_RST, T_OP_J, 6'h00, 1, 0);
      push_3cyc(T_JUMP, T_OP_J, 6'h00, 0);
      while (stim_q.size() > 0) begin
         apply_next(t);
         e = exp_q.pop_front();
         checks++;
         if (dut_outs() !== e) begin
            failures++;
            $display("FAIL mid_write_resume at %s actual=%h required=%h", t.name(), dut_outs(), e);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      reset     = 1'b1;
      mem_ready = 1'b0;
      alu_zero  = 1'b0;
      opcode    = 6'h00;
      funct     = 6'h00;
      @(negedge clk);
      test_reset();
      test_add();
      test_load_store();
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
